// File: rtl/logs_serial_map.sv
// Bit-serial logistic-map iterator: x' = r*x*(1-x) in fixed point, with both
// products computed on one shift-add accumulator and a programmable idle gap.
module logs_serial_map #(
    parameter int FRAC     = 8,
    parameter int X_INIT   = 1 << (FRAC - 1),
    parameter int ITER_DIV = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FRAC+1:0]   r,
    output logic [FRAC-1:0]   x,
    output logic              next_ready
);

    localparam int AW = 2 * FRAC + 2;
    localparam int CW = $clog2(FRAC + 2);
    localparam int DW = (ITER_DIV > 1) ? $clog2(ITER_DIV) : 1;
    localparam logic [FRAC-1:0] X_MAX = {FRAC{1'b1}};

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_DONE = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t          state_q;
    logic [FRAC-1:0] x_q;
    logic            next_ready_q;
    logic [FRAC+1:0] r_l_q;
    logic [AW-1:0]   mcand_q;
    logic [FRAC+1:0] mplier_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   wait_q;

    logic [AW-1:0]   acc_d;
    logic [FRAC:0]   b_init_s;
    logic [FRAC+1:0] n_s;

    // Shared adder for both products, plus the 1-x multiplier and the scaled result.
    always_comb begin
        acc_d    = acc_q;
        b_init_s = {1'b1, {FRAC{1'b0}}} - {1'b0, x_q};
        n_s      = acc_q[AW-1:FRAC];
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Iteration FSM; the second product reuses the accumulator after the first finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            x_q          <= FRAC'(X_INIT);
            next_ready_q <= 1'b0;
            r_l_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
        end else begin
            next_ready_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    r_l_q    <= r;
                    mcand_q  <= AW'(x_q);
                    mplier_q <= {1'b0, b_init_s};
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= S_MUL1;
                end
                S_MUL1: begin
                    if (cnt_q == CW'(FRAC)) begin
                        mcand_q  <= AW'(acc_d[AW-1:FRAC]);
                        mplier_q <= r_l_q;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_MUL2;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                S_MUL2: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CW'(FRAC + 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    // A zero result would lock the map at zero, so restart from X_INIT.
                    if (n_s == '0) begin
                        x_q <= FRAC'(X_INIT);
                    end else if (n_s[FRAC+1:FRAC] != 2'b00) begin
                        x_q <= X_MAX;
                    end else begin
                        x_q <= n_s[FRAC-1:0];
                    end
                    next_ready_q <= 1'b1;
                    if (ITER_DIV == 0) begin
                        state_q <= S_LOAD;
                    end else begin
                        wait_q  <= DW'(ITER_DIV - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_LOAD;
                    end else begin
                        wait_q  <= wait_q - DW'(1);
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign x          = x_q;
    assign next_ready = next_ready_q;

endmodule

// File: tb/tb_logs_serial_map.sv
// Directed bench for logs_serial_map: one instance with no idle gap, one with a 5-cycle gap.
module tb_logs_serial_map;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       reset_b;
    logic [9:0] r_a;
    logic [9:0] r_b;
    logic [7:0] x_a;
    logic [7:0] x_b;
    logic       nr_a;
    logic       nr_b;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    logs_serial_map #(.FRAC(8), .ITER_DIV(0)) dut0 (
        .clk        (clk),
        .reset      (reset_a),
        .r          (r_a),
        .x          (x_a),
        .next_ready (nr_a)
    );

    logs_serial_map #(.FRAC(8), .ITER_DIV(5)) dut5 (
        .clk        (clk),
        .reset      (reset_b),
        .r          (r_b),
        .x          (x_b),
        .next_ready (nr_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges until the selected instance strobes; -1 on timeout.
    task automatic wait_strobe(input int sel, output int cnt);
        logic hit;
        cnt = 0;
        hit = 1'b0;
        while (!hit && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            hit = (sel == 0) ? nr_a : nr_b;
        end
        if (!hit) cnt = -1;
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        r_a     = 10'd272;
        r_b     = 10'd272;

        // Scenario 1: reset values, then r = 1.0625 trajectory
        #2;
        check("s1_rst_x", x_a, 128);
        check("s1_rst_nr", nr_a, 0);
        repeat (3) @(negedge clk);
        check("s1_rst_x_held", x_a, 128);
        reset_a = 1'b0;
        #1;
        check("s1_rel_x", x_a, 128);
        check("s1_rel_nr", nr_a, 0);
        wait_strobe(0, n); check("s1_lat1", n, 21); check("s1_x1", x_a, 68);
        wait_strobe(0, n); check("s1_lat2", n, 21); check("s1_x2", x_a, 52);
        wait_strobe(0, n); check("s1_lat3", n, 21); check("s1_x3", x_a, 43);
        wait_strobe(0, n); check("s1_lat4", n, 21); check("s1_x4", x_a, 37);

        // Scenario 2: r = 1023 alternates 255 / 128
        @(negedge clk); reset_a = 1'b1; r_a = 10'd1023;
        @(negedge clk); reset_a = 1'b0;
        wait_strobe(0, n); check("s2_lat1", n, 21); check("s2_x1", x_a, 255);
        wait_strobe(0, n); check("s2_lat2", n, 21); check("s2_x2", x_a, 128);
        wait_strobe(0, n); check("s2_lat3", n, 21); check("s2_x3", x_a, 255);
        wait_strobe(0, n); check("s2_lat4", n, 21); check("s2_x4", x_a, 128);

        // Scenario 3: r = 0 always reloads 128
        @(negedge clk); reset_a = 1'b1; r_a = 10'd0;
        @(negedge clk); reset_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_strobe(0, n);
            check("s3_lat", n, 21);
            check("s3_x", x_a, 128);
        end

        // Scenario 4: r changes just after LOAD of iteration 1
        @(negedge clk); reset_a = 1'b1; r_a = 10'd272;
        @(negedge clk); reset_a = 1'b0;
        @(negedge clk); r_a = 10'd1023;
        wait_strobe(0, n); check("s4_lat1", n, 20); check("s4_x1", x_a, 68);
        wait_strobe(0, n); check("s4_lat2", n, 21); check("s4_x2", x_a, 195);

        // Scenario 6: async reset mid-MUL2 of iteration 2
        @(negedge clk); reset_a = 1'b1; r_a = 10'd272;
        @(negedge clk); reset_a = 1'b0;
        wait_strobe(0, n); check("s6_lat1", n, 21); check("s6_x1", x_a, 68);
        repeat (14) @(posedge clk);
        #3;
        reset_a = 1'b1;
        #1;
        check("s6_async_x", x_a, 128);
        check("s6_async_nr", nr_a, 0);
        repeat (3) @(negedge clk);
        reset_a = 1'b0;
        wait_strobe(0, n); check("s6_lat2", n, 21); check("s6_x2", x_a, 68);

        // Scenario 5: ITER_DIV = 5 instance, 26-cycle period, single-cycle pulse
        @(negedge clk); reset_b = 1'b0;
        wait_strobe(1, n); check("s5_lat1", n, 21); check("s5_x1", x_b, 68);
        @(posedge clk); #1; check("s5_pulse1", nr_b, 0);
        wait_strobe(1, n); check("s5_lat2", n, 25); check("s5_x2", x_b, 52);
        @(posedge clk); #1; check("s5_pulse2", nr_b, 0);
        wait_strobe(1, n); check("s5_lat3", n, 25); check("s5_x3", x_b, 43);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
